// File: rtl/rob_complete_arbiter.sv
// ROB completion arbiter: merges mem/mul/alu completions into one in-order
// queue that drains one entry per cycle into a registered ROB write port.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   in_flush            discard every pending completion
//   in_mem_*            memory-stage completion (idx, value, exception)
//   in_mul_*            multiply completion (idx, value; exception is 0)
//   in_alu_*            ALU completion (idx, value, exception)
//   out_rob_*           registered ROB completion write
//   out_stall           front-end freeze, driven from the registered count only
module rob_complete_arbiter #(
    parameter int DEPTH = 8,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_flush,
    input  logic             in_mem_complete,
    input  logic [IDX_W-1:0] in_mem_idx,
    input  logic [31:0]      in_mem_value,
    input  logic [2:0]       in_mem_exception,
    input  logic             in_mul_complete,
    input  logic [IDX_W-1:0] in_mul_idx,
    input  logic [31:0]      in_mul_value,
    input  logic             in_alu_complete,
    input  logic [IDX_W-1:0] in_alu_idx,
    input  logic [31:0]      in_alu_value,
    input  logic [2:0]       in_alu_exception,
    output logic             out_rob_complete,
    output logic [IDX_W-1:0] out_rob_idx,
    output logic [31:0]      out_rob_value,
    output logic [2:0]       out_rob_exception,
    output logic             out_stall
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int EW = IDX_W + 35;
    localparam int SW = CW + 2;

    // Entry layout: {idx, value, exception}
    logic [EW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_rd;
    logic [PW-1:0] r_wr;
    logic [CW-1:0] r_count;
    logic          r_out_v;
    logic [EW-1:0] r_out_e;

    logic [EW-1:0] w_src [3];
    logic [2:0]    w_src_v;
    logic [EW-1:0] w_arr [3];
    logic [1:0]    w_n;
    logic [EW-1:0] w_push [3];
    logic [1:0]    w_npush;
    logic [PW-1:0] w_waddr [3];
    logic          w_pop_q;
    logic          w_any;
    logic [EW-1:0] w_head;
    logic [SW-1:0] w_occ;
    logic [PW-1:0] w_rd_nxt;
    logic [PW-1:0] w_wr_nxt;

    // Pointer advance with explicit wrap so non-power-of-two depths work.
    function automatic logic [PW-1:0] f_wrap(
        input logic [PW-1:0] p,
        input logic [1:0]    k
    );
        logic [PW+1:0] s;
        s = {2'b00, p} + {{PW{1'b0}}, k};
        if (s >= (PW + 2)'(DEPTH))
            s = s - (PW + 2)'(DEPTH);
        return s[PW-1:0];
    endfunction

    assign w_src[0] = {in_mem_idx, in_mem_value, in_mem_exception};
    assign w_src[1] = {in_mul_idx, in_mul_value, 3'b000};
    assign w_src[2] = {in_alu_idx, in_alu_value, in_alu_exception};
    assign w_src_v  = {in_alu_complete, in_mul_complete, in_mem_complete};

    // Compact present sources into arrival order (mem, mul, alu), no holes.
    always_comb begin
        w_arr[0] = '0;
        w_arr[1] = '0;
        w_arr[2] = '0;
        w_n      = 2'd0;
        for (int k = 0; k < 3; k++) begin
            if (w_src_v[k]) begin
                w_arr[w_n] = w_src[k];
                w_n        = w_n + 2'd1;
            end
        end
    end

    assign w_pop_q = (r_count != '0);
    assign w_any   = w_pop_q || (w_n != 2'd0);

    // With an empty queue the oldest arrival bypasses storage and goes
    // straight to the output register; the rest are pushed.
    always_comb begin
        w_head    = w_arr[0];
        w_push[0] = w_arr[1];
        w_push[1] = w_arr[2];
        w_push[2] = '0;
        w_npush   = (w_n == 2'd0) ? 2'd0 : w_n - 2'd1;
        if (w_pop_q) begin
            w_head    = r_mem[r_rd];
            w_push[0] = w_arr[0];
            w_push[1] = w_arr[1];
            w_push[2] = w_arr[2];
            w_npush   = w_n;
        end
    end

    always_comb begin
        for (int j = 0; j < 3; j++)
            w_waddr[j] = f_wrap(r_wr, 2'(j));
    end

    assign w_occ    = SW'(r_count) + SW'(w_n) - SW'(w_any);
    assign w_rd_nxt = w_pop_q ? f_wrap(r_rd, 2'd1) : r_rd;
    assign w_wr_nxt = f_wrap(r_wr, w_npush);

    // Storage array needs no reset; validity is tracked by r_count.
    always_ff @(posedge clk) begin
        if (!reset && !in_flush) begin
            for (int j = 0; j < 3; j++) begin
                if (2'(j) < w_npush)
                    r_mem[w_waddr[j]] <= w_push[j];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
            r_out_v <= 1'b0;
            r_out_e <= '0;
        end else if (in_flush) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
            r_out_v <= 1'b0;
        end else begin
            r_rd    <= w_rd_nxt;
            r_wr    <= w_wr_nxt;
            r_count <= w_occ[CW-1:0];
            r_out_v <= w_any;
            if (w_any)
                r_out_e <= w_head;
        end
    end

    assign out_rob_complete  = r_out_v;
    assign out_rob_idx       = r_out_e[EW-1 -: IDX_W];
    assign out_rob_value     = r_out_e[34:3];
    assign out_rob_exception = r_out_e[2:0];

    // Fewer than three free slots: a full cycle of arrivals could overflow.
    assign out_stall = (r_count > CW'(DEPTH - 3));

    a_no_overflow : assert property (
        @(posedge clk) disable iff (reset || in_flush)
        w_occ <= SW'(DEPTH)
    );

endmodule

// File: tb/tb_rob_complete_arbiter.sv
// Self-checking bench for rob_complete_arbiter against a queue-based
// reference model of the completion sequence.
module tb_rob_complete_arbiter;

    localparam int DEPTH = 8;
    localparam int IDX_W = 4;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [31:0]      val;
        logic [2:0]       exc;
    } entry_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_flush;
    logic             in_mem_complete;
    logic [IDX_W-1:0] in_mem_idx;
    logic [31:0]      in_mem_value;
    logic [2:0]       in_mem_exception;
    logic             in_mul_complete;
    logic [IDX_W-1:0] in_mul_idx;
    logic [31:0]      in_mul_value;
    logic             in_alu_complete;
    logic [IDX_W-1:0] in_alu_idx;
    logic [31:0]      in_alu_value;
    logic [2:0]       in_alu_exception;
    logic             out_rob_complete;
    logic [IDX_W-1:0] out_rob_idx;
    logic [31:0]      out_rob_value;
    logic [2:0]       out_rob_exception;
    logic             out_stall;

    int n_tests = 0;
    int n_fail  = 0;

    entry_t mq[$];
    logic   e_cmp;
    entry_t e_ent;

    rob_complete_arbiter #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
        .clk(clk),
        .reset(reset),
        .in_flush(in_flush),
        .in_mem_complete(in_mem_complete),
        .in_mem_idx(in_mem_idx),
        .in_mem_value(in_mem_value),
        .in_mem_exception(in_mem_exception),
        .in_mul_complete(in_mul_complete),
        .in_mul_idx(in_mul_idx),
        .in_mul_value(in_mul_value),
        .in_alu_complete(in_alu_complete),
        .in_alu_idx(in_alu_idx),
        .in_alu_value(in_alu_value),
        .in_alu_exception(in_alu_exception),
        .out_rob_complete(out_rob_complete),
        .out_rob_idx(out_rob_idx),
        .out_rob_value(out_rob_value),
        .out_rob_exception(out_rob_exception),
        .out_stall(out_stall)
    );

    always #5 clk = ~clk;

    function automatic logic exp_stall();
        return (DEPTH - mq.size()) < 3;
    endfunction

    task automatic clr_in();
        in_flush         = 1'b0;
        in_mem_complete  = 1'b0;
        in_mem_idx       = '0;
        in_mem_value     = '0;
        in_mem_exception = '0;
        in_mul_complete  = 1'b0;
        in_mul_idx       = '0;
        in_mul_value     = '0;
        in_alu_complete  = 1'b0;
        in_alu_idx       = '0;
        in_alu_value     = '0;
        in_alu_exception = '0;
    endtask

    task automatic set_mem(input int idx, input logic [31:0] v, input logic [2:0] e);
        in_mem_complete  = 1'b1;
        in_mem_idx       = IDX_W'(idx);
        in_mem_value     = v;
        in_mem_exception = e;
    endtask

    task automatic set_mul(input int idx, input logic [31:0] v);
        in_mul_complete = 1'b1;
        in_mul_idx      = IDX_W'(idx);
        in_mul_value    = v;
    endtask

    task automatic set_alu(input int idx, input logic [31:0] v, input logic [2:0] e);
        in_alu_complete  = 1'b1;
        in_alu_idx       = IDX_W'(idx);
        in_alu_value     = v;
        in_alu_exception = e;
    endtask

    // Advance the reference model by the cycle's inputs, then let the DUT
    // take the same clock edge and settle.
    task automatic tick();
        entry_t seq[$];
        if (reset) begin
            mq.delete();
            e_cmp = 1'b0;
            e_ent = '0;
        end else if (in_flush) begin
            mq.delete();
            e_cmp = 1'b0;
        end else begin
            seq = mq;
            if (in_mem_complete)
                seq.push_back('{in_mem_idx, in_mem_value, in_mem_exception});
            if (in_mul_complete)
                seq.push_back('{in_mul_idx, in_mul_value, 3'b000});
            if (in_alu_complete)
                seq.push_back('{in_alu_idx, in_alu_value, in_alu_exception});
            if (seq.size() > 0) begin
                e_ent = seq.pop_front();
                e_cmp = 1'b1;
            end else begin
                e_cmp = 1'b0;
            end
            mq = seq;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clr_in();
        reset = 1'b1;
        tick();
        tick();
        n_tests++;
        if ({out_rob_complete, out_rob_idx, out_rob_value, out_rob_exception, out_stall} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got=%h exp=0",
                {out_rob_complete, out_rob_idx, out_rob_value, out_rob_exception, out_stall});
        end
        n_tests++;
        if (dut.r_count !== '0) begin
            n_fail++;
            $display("FAIL reset_count got=%0d exp=0", dut.r_count);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single_alu();
        set_alu(3, 32'h0000_002A, 3'b000);
        tick();
        clr_in();
        n_tests++;
        if ({out_rob_complete, out_rob_idx, out_rob_value, out_rob_exception, out_stall}
            !== {1'b1, 4'd3, 32'h2A, 3'b000, 1'b0}) begin
            n_fail++;
            $display("FAIL single_alu_out got=%b/%0d/%h/%b stall=%b exp=1/3/2a/000 stall=0",
                out_rob_complete, out_rob_idx, out_rob_value, out_rob_exception, out_stall);
        end
        tick();
        n_tests++;
        if ({out_rob_complete, out_stall} !== 2'b00) begin
            n_fail++;
            $display("FAIL single_alu_idle got=%b/%b exp=0/0", out_rob_complete, out_stall);
        end
    endtask

    task automatic test_same_cycle();
        int exp_cnt [3] = '{2, 1, 0};
        set_mem(1, 32'h11, 3'b000);
        set_mul(2, 32'h22);
        set_alu(3, 32'h33, 3'b000);
        for (int c = 0; c < 3; c++) begin
            tick();
            clr_in();
            n_tests++;
            if (!(out_rob_complete === 1'b1 && out_rob_idx === IDX_W'(c + 1)
                  && out_rob_value === 32'((c + 1) * 32'h11)
                  && int'(dut.r_count) == exp_cnt[c])) begin
                n_fail++;
                $display("FAIL same_cycle_%0d got=%b/%0d/%h cnt=%0d exp=1/%0d/%h cnt=%0d",
                    c, out_rob_complete, out_rob_idx, out_rob_value, dut.r_count,
                    c + 1, (c + 1) * 32'h11, exp_cnt[c]);
            end
        end
        tick();
        n_tests++;
        if (out_rob_complete !== 1'b0) begin
            n_fail++;
            $display("FAIL same_cycle_done got=%b exp=0", out_rob_complete);
        end
    endtask

    task automatic test_stall_fill();
        int got[$];
        int exp_cnt [3] = '{2, 4, 6};
        logic exp_st [3] = '{1'b0, 1'b0, 1'b1};
        for (int c = 0; c < 3; c++) begin
            set_mem(3 * c + 1, $urandom, 3'b000);
            set_mul(3 * c + 2, $urandom);
            set_alu(3 * c + 3, $urandom, 3'b000);
            tick();
            clr_in();
            if (out_rob_complete) got.push_back(int'(out_rob_idx));
            n_tests++;
            if (int'(dut.r_count) != exp_cnt[c] || out_stall !== exp_st[c]) begin
                n_fail++;
                $display("FAIL stall_fill_%0d cnt=%0d stall=%b exp cnt=%0d stall=%b",
                    c, dut.r_count, out_stall, exp_cnt[c], exp_st[c]);
            end
        end
        tick();
        if (out_rob_complete) got.push_back(int'(out_rob_idx));
        n_tests++;
        if (int'(dut.r_count) != 5 || out_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_release cnt=%0d stall=%b exp cnt=5 stall=0",
                dut.r_count, out_stall);
        end
        for (int c = 0; c < 20 && got.size() < 9; c++) begin
            tick();
            if (out_rob_complete) got.push_back(int'(out_rob_idx));
        end
        n_tests++;
        if (got.size() != 9) begin
            n_fail++;
            $display("FAIL stall_drain_count got=%0d exp=9", got.size());
        end else begin
            for (int i = 0; i < 9; i++) begin
                n_tests++;
                if (got[i] != i + 1) begin
                    n_fail++;
                    $display("FAIL stall_order_%0d got=%0d exp=%0d", i, got[i], i + 1);
                end
            end
        end
        tick();
    endtask

    task automatic test_flush();
        for (int c = 0; c < 2; c++) begin
            set_mem(1, $urandom, 3'b000);
            set_mul(2, $urandom);
            set_alu(3, $urandom, 3'b000);
            tick();
        end
        clr_in();
        n_tests++;
        if (int'(dut.r_count) != 4) begin
            n_fail++;
            $display("FAIL flush_prefill cnt=%0d exp=4", dut.r_count);
        end
        in_flush = 1'b1;
        set_alu(7, 32'h77, 3'b000);
        tick();
        clr_in();
        n_tests++;
        if (out_rob_complete !== 1'b0 || dut.r_count !== '0 || out_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_state got=%b cnt=%0d stall=%b exp=0 cnt=0 stall=0",
                out_rob_complete, dut.r_count, out_stall);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            n_tests++;
            if (out_rob_complete !== 1'b0) begin
                n_fail++;
                $display("FAIL flush_leak_%0d got=%b idx=%0d exp=0",
                    c, out_rob_complete, out_rob_idx);
            end
        end
    endtask

    task automatic test_exception_order();
        set_mem(4, 32'h44, 3'b000);
        set_alu(5, 32'h55, 3'b010);
        tick();
        clr_in();
        n_tests++;
        if ({out_rob_complete, out_rob_idx, out_rob_exception} !== {1'b1, 4'd4, 3'b000}) begin
            n_fail++;
            $display("FAIL exc_first got=%b/%0d/%b exp=1/4/000",
                out_rob_complete, out_rob_idx, out_rob_exception);
        end
        tick();
        n_tests++;
        if ({out_rob_complete, out_rob_idx, out_rob_exception} !== {1'b1, 4'd5, 3'b010}) begin
            n_fail++;
            $display("FAIL exc_second got=%b/%0d/%b exp=1/5/010",
                out_rob_complete, out_rob_idx, out_rob_exception);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 3; c++) begin
            set_mem(1, $urandom, 3'b001);
            set_mul(2, $urandom);
            if (c < 2) set_alu(3, $urandom, 3'b000);
            tick();
            clr_in();
        end
        n_tests++;
        if (int'(dut.r_count) != 5) begin
            n_fail++;
            $display("FAIL reset_mid_prefill cnt=%0d exp=5", dut.r_count);
        end
        reset = 1'b1;
        set_alu(6, 32'h66, 3'b000);
        tick();
        clr_in();
        n_tests++;
        if ({out_rob_complete, out_rob_idx, out_rob_value, out_rob_exception, out_stall} !== '0
            || dut.r_count !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_state got=%h cnt=%0d exp=0 cnt=0",
                {out_rob_complete, out_rob_idx, out_rob_value, out_rob_exception, out_stall},
                dut.r_count);
        end
        reset = 1'b0;
        set_mem(9, 32'h99, 3'b000);
        tick();
        clr_in();
        n_tests++;
        if ({out_rob_complete, out_rob_idx, out_rob_value} !== {1'b1, 4'd9, 32'h99}) begin
            n_fail++;
            $display("FAIL reset_mid_after got=%b/%0d/%h exp=1/9/99",
                out_rob_complete, out_rob_idx, out_rob_value);
        end
        tick();
    endtask

    task automatic test_random();
        int bad = 0;
        for (int c = 0; c < 3000; c++) begin
            clr_in();
            reset = ($urandom_range(0, 199) == 0);
            in_flush = ($urandom_range(0, 39) == 0);
            if (!exp_stall()) begin
                if ($urandom_range(0, 1) == 1)
                    set_mem($urandom_range(0, 15), $urandom, 3'($urandom));
                if ($urandom_range(0, 1) == 1)
                    set_mul($urandom_range(0, 15), $urandom);
                if ($urandom_range(0, 1) == 1)
                    set_alu($urandom_range(0, 15), $urandom, 3'($urandom));
            end
            tick();
            n_tests++;
            if ({out_rob_complete, out_rob_idx, out_rob_value, out_rob_exception, out_stall}
                !== {e_cmp, e_ent, exp_stall()}
                || int'(dut.r_count) != mq.size()) begin
                n_fail++;
                bad++;
                if (bad <= 10)
                    $display("FAIL random_c%0d got=%b/%0d/%h/%b st=%b cnt=%0d exp=%b/%0d/%h/%b st=%b cnt=%0d",
                        c, out_rob_complete, out_rob_idx, out_rob_value, out_rob_exception,
                        out_stall, dut.r_count, e_cmp, e_ent.idx, e_ent.val, e_ent.exc,
                        exp_stall(), mq.size());
            end
        end
        clr_in();
        reset = 1'b0;
    endtask

    initial begin
        e_cmp = 1'b0;
        e_ent = '0;
        reset = 1'b1;
        clr_in();
        test_reset();
        test_single_alu();
        test_same_cycle();
        test_stall_fill();
        test_flush();
        test_exception_order();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
